dma_bus_initiator: RTL and testbench
====================================

Name: dma_bus_initiator

Overview:
Word-copy DMA engine that acts as a second initiator on the SoC peripheral bus, the counterpart to the timer/LED/RAM responders. It is started by a sideband command (source, destination, word count) and drives the bus to copy each word with a read followed by a write. Typical uses are RAM-to-LED pattern streaming and RAM block copies. It signals completion with a done pulse and a sticky interrupt, and a per-access ready timeout flags bus errors.

Parameters:
TIMEOUT_CYCLES, 16, maximum wait in cycles for bus_ready per access before aborting (range 1..255).
ADDR_STRIDE, 4, byte increment applied to src/dst after each word.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle command strobe, sampled only in IDLE
src_addr  input  32  source byte address, latched on accepted start
dst_addr  input  32  destination byte address, latched on accepted start
length  input  16  words to copy, latched on accepted start
busy  output  1  high from the cycle after an accepted start until return to IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky timeout flag, cleared by the next accepted start or by reset
words_done  output  16  count of words fully written in the current or last transfer
irq  output  1  level interrupt, set with done or error, cleared by irq_ack
irq_ack  input  1  interrupt acknowledge; if it coincides with a set event, the set wins
bus_addr  output  32  bus byte address
bus_wdata  output  32  bus write data
bus_rdata  input  32  bus read data (from the responder mux)
bus_we  output  1  write strobe
bus_re  output  1  read strobe
bus_ready  input  1  responder completion; data valid and write accepted in the cycle it is high

Behaviour:
- Reset values: busy, done, error, irq, bus_we and bus_re are 0; bus_addr, bus_wdata and words_done are 0; state is IDLE; internal src, dst, remaining and buffer registers are 0.
- Reset mid-transfer aborts immediately. No strobe is asserted in the cycle after reset is sampled. The transfer is not resumed.
- All outputs are registered and are functions of the state (Moore). bus_we and bus_re are never high together.
- IDLE: start=1 latches the command.
  - length=0: go to DONE with no bus cycles.
  - Otherwise: go to READ; error is cleared and words_done is cleared.
  - start outside IDLE is ignored.
- READ: bus_re=1, bus_addr=src. Held stable until bus_ready=1.
  - On ready, capture bus_rdata into the buffer and go to WRITE.
- WRITE: bus_we=1, bus_addr=dst, bus_wdata=buffer. Held stable until bus_ready=1.
  - On ready: src+=ADDR_STRIDE, dst+=ADDR_STRIDE, remaining-=1, words_done+=1.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: done=1 for exactly one cycle, irq set, then IDLE. busy drops in the same cycle done rises.
- ERR: entered when the wait counter reaches TIMEOUT_CYCLES in READ or WRITE without bus_ready.
  - Strobes deassert; error=1 and irq set; next state is IDLE.
  - words_done holds the count of completed words.
- Timeout counter: cleared on entry to READ or WRITE, increments each cycle bus_ready=0. bus_ready in the same cycle the count hits the limit counts as success.
- Throughput with zero-wait responders: 2 cycles per word. An N-word copy has done high at cycle 2N+1 after the start cycle.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0x00000000 without an error.
- Overlapping src/dst regions are not detected; copy order is ascending.

Decomposition:
- Shared package soc_bus_pkg:
  - DMA state encoding (IDLE, READ, WRITE, DONE, ERR).
  - Region base constants: TIMER_BASE 32'h4000_0000, LED_BASE 32'h4001_0000, RAM_BASE 32'h2000_0000.
  - WORD_BYTES=4.
- One sub-module, bus_timeout_counter: a clear/enable/limit counter with a single expired output, reused later by other initiators.

Test Plan:
- Zero-wait copy: src=0x2000_0000, dst=0x2000_0040, length=3, RAM preloaded 0xA1/0xB2/0xC3, bus_ready tied high. Required:
  - Accesses in order R, W, R, W, R, W.
  - Writes to 0x40, 0x44, 0x48 carry 0xA1, 0xB2, 0xC3.
  - done pulses at cycle 7; words_done=3; irq=1.
- Wait states: responder delays bus_ready by 3 cycles on each access. Required:
  - bus_addr, strobes and bus_wdata held stable throughout each wait.
  - Copy completes with correct data; no error.
- Timeout: TIMEOUT_CYCLES=16, bus_ready stuck 0 during the second word's write. Required:
  - error=1, irq=1, busy=0 after exactly 16 wait cycles.
  - words_done=1; no further strobes.
- Zero length and busy start: length=0 gives done in the next cycle with no strobes. A start pulse issued mid-transfer is ignored; the original src/dst/length are unaffected.
- Address wrap: src=0xFFFF_FFFC, length=2. Required: second read issued at 0x0000_0000; no error.
- Reset mid-transfer and irq: reset asserted during WRITE. Required:
  - Next cycle all outputs are 0 and state is IDLE.
  - Separately: irq_ack clears irq; irq_ack coinciding with done leaves irq=1.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// -----------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for initiators and responders on the SoC peripheral bus.
//   - dma_state_e  : state encoding of the DMA bus initiator
//   - *_BASE       : responder region base addresses
//   - WORD_BYTES   : bytes per bus word
//   - addr_advance : modulo-2^32 byte-address increment
// -----------------------------------------------------------------------------
package soc_bus_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_READ  = 3'd1,
        DMA_WRITE = 3'd2,
        DMA_DONE  = 3'd3,
        DMA_ERR   = 3'd4
    } dma_state_e;

    localparam logic [31:0] TIMER_BASE = 32'h4000_0000;
    localparam logic [31:0] LED_BASE   = 32'h4001_0000;
    localparam logic [31:0] RAM_BASE   = 32'h2000_0000;

    localparam int WORD_BYTES = 4;

    // Address step; the carry out of bit 31 is dropped so addresses wrap.
    function automatic logic [31:0] addr_advance(input logic [31:0] addr,
                                                 input logic [31:0] stride);
        return addr + stride;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// bus_timeout_counter
// Counts consecutive enabled cycles of a pending bus access and flags expiry.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   clear   in   restart the count (takes priority over enable)
//   enable  in   one wait cycle elapsed in this cycle
//   limit   in   [7:0] number of wait cycles allowed (1..255)
//   expired out  this cycle is the limit-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module bus_timeout_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_r;

    // Wait-cycle count; saturates at the limit so it never wraps back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable && (count_r != limit)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // count_r holds the waits already seen, so the limit is reached when this
    // enabled cycle would be number 'limit'.
    assign expired = enable && !clear && (count_r == (limit - 8'd1));

endmodule

// File: rtl/dma_bus_initiator.sv
// -----------------------------------------------------------------------------
// dma_bus_initiator
// Word-copy DMA engine acting as a bus initiator. A sideband start command
// (src, dst, length) launches a copy of 'length' words, each done as a bus
// read followed by a bus write, in ascending address order.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 command strobe, accepted only when idle
//   src_addr/dst_addr     byte addresses latched on an accepted start
//   length                word count latched on an accepted start
//   busy                  copy in progress (read/write phases)
//   done                  one-cycle pulse on successful completion
//   error                 sticky ready-timeout flag
//   words_done            words fully written in the current/last transfer
//   irq / irq_ack         level interrupt and its acknowledge
//   bus_addr/bus_wdata    bus address and write data
//   bus_re/bus_we         read/write strobes, never high together
//   bus_rdata/bus_ready   responder data and completion
// All outputs are registered and decoded from the state being entered.
// -----------------------------------------------------------------------------
module dma_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_STRIDE    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done,
    output logic        irq,
    input  logic        irq_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic        bus_ready
);

    import soc_bus_pkg::*;

    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);
    localparam logic [7:0]  LIMIT  = 8'(TIMEOUT_CYCLES);

    dma_state_e  state_r, state_n;
    logic [31:0] src_r, src_n;
    logic [31:0] dst_r, dst_n;
    logic [15:0] rem_r, rem_n;
    logic [31:0] buf_r, buf_n;
    logic [15:0] words_r, words_n;
    logic        error_r, error_n;
    logic        irq_r, irq_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic        re_r, re_n;
    logic        we_r, we_n;
    logic [31:0] addr_r, addr_n;
    logic [31:0] wdata_r, wdata_n;

    logic in_access_s;
    logic tmo_clear_s;
    logic tmo_enable_s;
    logic expired_s;

    // A wait cycle is any cycle of a pending access without ready; the count
    // restarts whenever the access completes or no access is pending.
    always_comb begin
        in_access_s  = (state_r == DMA_READ) || (state_r == DMA_WRITE);
        tmo_clear_s  = !in_access_s || bus_ready;
        tmo_enable_s = in_access_s && !bus_ready;
    end

    bus_timeout_counter u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .limit   (LIMIT),
        .expired (expired_s)
    );

    // Next-state and datapath update.
    always_comb begin
        state_n = state_r;
        src_n   = src_r;
        dst_n   = dst_r;
        rem_n   = rem_r;
        buf_n   = buf_r;
        words_n = words_r;
        error_n = error_r;
        case (state_r)
            DMA_IDLE: begin
                if (start) begin
                    src_n   = src_addr;
                    dst_n   = dst_addr;
                    rem_n   = length;
                    error_n = 1'b0;
                    words_n = 16'd0;
                    if (length == 16'd0) begin
                        state_n = DMA_DONE;
                    end else begin
                        state_n = DMA_READ;
                    end
                end else begin
                    state_n = DMA_IDLE;
                end
            end
            DMA_READ: begin
                if (bus_ready) begin
                    buf_n   = bus_rdata;
                    state_n = DMA_WRITE;
                end else if (expired_s) begin
                    error_n = 1'b1;
                    state_n = DMA_ERR;
                end else begin
                    state_n = DMA_READ;
                end
            end
            DMA_WRITE: begin
                if (bus_ready) begin
                    src_n   = addr_advance(src_r, STRIDE);
                    dst_n   = addr_advance(dst_r, STRIDE);
                    rem_n   = rem_r - 16'd1;
                    words_n = words_r + 16'd1;
                    if (rem_r == 16'd1) begin
                        state_n = DMA_DONE;
                    end else begin
                        state_n = DMA_READ;
                    end
                end else if (expired_s) begin
                    error_n = 1'b1;
                    state_n = DMA_ERR;
                end else begin
                    state_n = DMA_WRITE;
                end
            end
            DMA_DONE: begin
                state_n = DMA_IDLE;
            end
            DMA_ERR: begin
                state_n = DMA_IDLE;
            end
            default: begin
                state_n = DMA_IDLE;
            end
        endcase
    end

    // Moore output decode from the state being entered, so the registered
    // outputs line up with the state register.
    always_comb begin
        busy_n  = 1'b0;
        done_n  = 1'b0;
        re_n    = 1'b0;
        we_n    = 1'b0;
        addr_n  = 32'h0000_0000;
        wdata_n = 32'h0000_0000;
        case (state_n)
            DMA_READ: begin
                busy_n = 1'b1;
                re_n   = 1'b1;
                addr_n = src_n;
            end
            DMA_WRITE: begin
                busy_n  = 1'b1;
                we_n    = 1'b1;
                addr_n  = dst_n;
                wdata_n = buf_n;
            end
            DMA_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
        // A set event beats a coincident acknowledge.
        if ((state_n == DMA_DONE) || (state_n == DMA_ERR)) begin
            irq_n = 1'b1;
        end else if (irq_ack) begin
            irq_n = 1'b0;
        end else begin
            irq_n = irq_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= DMA_IDLE;
            src_r   <= 32'h0000_0000;
            dst_r   <= 32'h0000_0000;
            rem_r   <= 16'd0;
            buf_r   <= 32'h0000_0000;
            words_r <= 16'd0;
            error_r <= 1'b0;
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            re_r    <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_n;
            src_r   <= src_n;
            dst_r   <= dst_n;
            rem_r   <= rem_n;
            buf_r   <= buf_n;
            words_r <= words_n;
            error_r <= error_n;
            irq_r   <= irq_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            re_r    <= re_n;
            we_r    <= we_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign words_done = words_r;
    assign irq        = irq_r;
    assign bus_addr   = addr_r;
    assign bus_wdata  = wdata_r;
    assign bus_re     = re_r;
    assign bus_we     = we_r;

endmodule

// File: tb/tb_dma_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_initiator
// Directed bench for dma_bus_initiator. A bench responder serves reads from a
// preloaded word array and captures writes into a separate array. A transfer
// model turns each command into the ordered list of bus accesses it must
// produce; one compare process checks every strobe cycle against the head of
// that list. Directed checks pin completion cycles, counters and flags.
// -----------------------------------------------------------------------------
module tb_dma_bus_initiator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic        irq;
    logic        irq_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_we;
    logic        bus_re;
    logic        bus_ready;

    dma_bus_initiator #(.TIMEOUT_CYCLES(16), .ADDR_STRIDE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_ready  (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- responder ----------------
    logic [31:0] mem    [0:1023];   // read data, written only by stimulus
    logic [31:0] wr_mem [0:1023];   // captured writes, written only by responder
    int wait_cfg;                   // wait cycles before ready on each access
    int stall_at;                   // access index that never gets ready (-1: none)
    int pend;
    int acc_idx;
    logic rsp_clr;

    always_comb begin
        bus_ready = 1'b0;
        if ((bus_re || bus_we) && (pend >= wait_cfg) && (acc_idx != stall_at)) bus_ready = 1'b1;
        bus_rdata = bus_re ? mem[bus_addr[11:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (reset || rsp_clr) begin
            pend    <= 0;
            acc_idx <= 0;
        end else if ((bus_re || bus_we) && bus_ready) begin
            if (bus_we) wr_mem[bus_addr[11:2]] <= bus_wdata;
            pend    <= 0;
            acc_idx <= acc_idx + 1;
        end else if (bus_re || bus_we) begin
            pend <= pend + 1;
        end else begin
            pend <= 0;
        end
    end

    // ---------------- transfer model ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t exp_q[$];

    // Word i of a copy is a read of src+4i then a write of that word to dst+4i.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = s + 32'(4 * i);
            exp_q.push_back('{1'b0, a, 32'h0});
            exp_q.push_back('{1'b1, d + 32'(4 * i), mem[a[11:2]]});
        end
    endtask

    // Every non-reset cycle: strobes exclusive, busy exactly while a strobe is
    // up, and any strobe matches the next planned access (held until ready).
    always @(negedge clk) begin
        acc_t cur;
        if (!reset) begin
            chk1("strobe_excl", bus_re & bus_we, 1'b0);
            chk1("busy_vs_strobe", busy, bus_re | bus_we);
            if (bus_re || bus_we) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_strobe: got re=%b we=%b addr=%h, expected no access (t=%0t)",
                             bus_re, bus_we, bus_addr, $time);
                end else begin
                    cur = exp_q[0];
                    chk1("acc_kind", bus_we, cur.wr);
                    chk32("acc_addr", bus_addr, cur.addr);
                    if (cur.wr) chk32("acc_wdata", bus_wdata, cur.data);
                    if (bus_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; length = n; rsp_clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rsp_clr = 1'b0;
    endtask

    // Returns the cycle (counted from the start cycle = 0) in which done (or
    // error) is first seen; -1 when the budget runs out.
    task automatic wait_for(input bit on_err, input int first, input int budget, output int cyc);
        cyc = first;
        forever begin
            @(negedge clk);
            if (on_err ? (error === 1'b1) : (done === 1'b1)) break;
            if (cyc >= budget) begin
                cyc = -1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic ack_irq();
        @(posedge clk); #1;
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        @(negedge clk);
        chk1("irq_ack_clears", irq, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int cyc;
        vectors = 0; miscompares = 0;
        reset = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; length = 16'd0;
        irq_ack = 1'b0; rsp_clr = 1'b0; wait_cfg = 0; stall_at = -1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);   chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0); chk1("rst_irq", irq, 1'b0);
        chk1("rst_re", bus_re, 1'b0);   chk1("rst_we", bus_we, 1'b0);
        chk32("rst_addr", bus_addr, 32'h0); chk32("rst_wdata", bus_wdata, 32'h0);
        chk32("rst_words", 32'(words_done), 32'h0);
        @(posedge clk); #1; reset = 1'b0;

        // Zero-wait 3-word copy
        mem[0] = 32'h0000_00A1; mem[1] = 32'h0000_00B2; mem[2] = 32'h0000_00C3;
        plan(32'h2000_0000, 32'h2000_0040, 3);
        run_start(32'h2000_0000, 32'h2000_0040, 16'd3);
        wait_for(1'b0, 1, 20, cyc);
        chk32("copy_done_cycle", 32'(cyc), 32'd7);
        chk32("copy_words", 32'(words_done), 32'd3);
        chk1("copy_irq", irq, 1'b1);
        chk1("copy_error", error, 1'b0);
        chk32("copy_q_empty", 32'(exp_q.size()), 32'd0);
        chk32("copy_w40", wr_mem[16], 32'h0000_00A1);
        chk32("copy_w44", wr_mem[17], 32'h0000_00B2);
        chk32("copy_w48", wr_mem[18], 32'h0000_00C3);
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
        ack_irq();

        // Three wait states per access; irq_ack held so it coincides with done
        wait_cfg = 3;
        mem[64] = 32'h1111_2222; mem[65] = 32'h3333_4444;
        irq_ack = 1'b1;
        plan(32'h2000_0100, 32'h2000_0200, 2);
        run_start(32'h2000_0100, 32'h2000_0200, 16'd2);
        wait_for(1'b0, 1, 40, cyc);
        irq_ack = 1'b0;
        chk32("wait_done_cycle", 32'(cyc), 32'd17);
        chk1("ack_vs_set_irq", irq, 1'b1);
        chk1("wait_error", error, 1'b0);
        chk32("wait_w0", wr_mem[128], 32'h1111_2222);
        chk32("wait_w1", wr_mem[129], 32'h3333_4444);
        @(negedge clk);
        chk1("irq_held", irq, 1'b1);
        wait_cfg = 0;
        ack_irq();

        // Timeout on the second word's write
        stall_at = 3;
        plan(32'h2000_0000, 32'h2000_0300, 3);
        run_start(32'h2000_0000, 32'h2000_0300, 16'd3);
        wait_for(1'b1, 1, 40, cyc);
        chk32("tmo_cycle", 32'(cyc), 32'd20);
        chk1("tmo_busy", busy, 1'b0);
        chk1("tmo_irq", irq, 1'b1);
        chk1("tmo_done", done, 1'b0);
        chk32("tmo_words", 32'(words_done), 32'd1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk1("tmo_sticky", error, 1'b1);
        stall_at = -1;

        // Start while busy is ignored; an accepted start clears error
        plan(32'h2000_0000, 32'h2000_0080, 2);
        run_start(32'h2000_0000, 32'h2000_0080, 16'd2);
        @(negedge clk);
        chk1("start_clears_error", error, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; src_addr = 32'h2000_0100; dst_addr = 32'h2000_0500; length = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_for(1'b0, 3, 20, cyc);
        chk32("busy_start_done_cycle", 32'(cyc), 32'd5);
        chk32("busy_start_words", 32'(words_done), 32'd2);
        chk32("busy_start_q_empty", 32'(exp_q.size()), 32'd0);
        chk32("busy_start_w1", wr_mem[33], 32'h0000_00B2);
        repeat (3) @(negedge clk);

        // Zero length: done in the next cycle, no strobes
        plan(32'h2000_0000, 32'h2000_0000, 0);
        run_start(32'h2000_0000, 32'h2000_0000, 16'd0);
        wait_for(1'b0, 1, 10, cyc);
        chk32("zero_len_done_cycle", 32'(cyc), 32'd1);
        chk32("zero_len_words", 32'(words_done), 32'd0);
        repeat (3) @(negedge clk);

        // Source address wrap
        mem[1023] = 32'hDEAD_BEEF;
        plan(32'hFFFF_FFFC, 32'h2000_0400, 2);
        run_start(32'hFFFF_FFFC, 32'h2000_0400, 16'd2);
        wait_for(1'b0, 1, 20, cyc);
        chk32("wrap_done_cycle", 32'(cyc), 32'd5);
        chk1("wrap_error", error, 1'b0);
        chk32("wrap_w0", wr_mem[256], 32'hDEAD_BEEF);
        chk32("wrap_w1", wr_mem[257], 32'h0000_00A1);

        // Reset during a write
        plan(32'h2000_0000, 32'h2000_0600, 3);
        run_start(32'h2000_0000, 32'h2000_0600, 16'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mid_pre_we", bus_we, 1'b1);
        chk1("mid_pre_irq", irq, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk1("mid_busy", busy, 1'b0);   chk1("mid_done", done, 1'b0);
        chk1("mid_error", error, 1'b0); chk1("mid_irq", irq, 1'b0);
        chk1("mid_re", bus_re, 1'b0);   chk1("mid_we", bus_we, 1'b0);
        chk32("mid_addr", bus_addr, 32'h0); chk32("mid_wdata", bus_wdata, 32'h0);
        chk32("mid_words", 32'(words_done), 32'h0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
